// File: rtl/fwd_ctrl_if.sv
// ID-stage handshake between the decode stage and the forwarding/hazard controller.
// The master drives the instruction in ID; the controller answers with stall and EX selects.
interface fwd_ctrl_if #(
    parameter int AW = 3
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_rd;
    logic          id_we;
    logic          id_ld;
    logic          flush;
    logic          stall;
    logic [1:0]    ex_sel_a;
    logic [1:0]    ex_sel_b;
    logic          ex_valid;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_we, id_ld, flush,
        input  stall, ex_sel_a, ex_sel_b, ex_valid
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_we, id_ld, flush,
        output stall, ex_sel_a, ex_sel_b, ex_valid
    );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM destinations and produces
// registered EX operand mux selects (0 = regfile, 1 = EX/MEM, 2 = MEM/WB) plus a load-use stall.
module fwd_ctrl #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    fwd_ctrl_if.slave  bus
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    logic          ex_valid_q,  ex_valid_d;
    logic [AW-1:0] ex_rd_q,     ex_rd_d;
    logic          ex_we_q,     ex_we_d;
    logic          ex_ld_q,     ex_ld_d;
    logic          mem_valid_q, mem_valid_d;
    logic [AW-1:0] mem_rd_q,    mem_rd_d;
    logic          mem_we_q,    mem_we_d;
    logic [1:0]    sel_a_q,     sel_a_d;
    logic [1:0]    sel_b_q,     sel_b_d;

    logic ex_wr;
    logic mem_wr;
    logic stall_c;

    // Youngest producer wins; register 0 never forwards because writers exclude rd 0.
    function automatic logic [1:0] pick_sel(
        input logic [AW-1:0] src,
        input logic          ex_w,
        input logic [AW-1:0] ex_rd,
        input logic          mem_w,
        input logic [AW-1:0] mem_rd
    );
        if (ex_w && (ex_rd == src))
            return SEL_EX;
        else if (mem_w && (mem_rd == src))
            return SEL_MEM;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        ex_wr   = ex_valid_q && ex_we_q && (ex_rd_q != '0);
        mem_wr  = mem_valid_q && mem_we_q && (mem_rd_q != '0);
        stall_c = bus.id_valid && !bus.flush && ex_wr && ex_ld_q &&
                  ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));

        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_we_d    = ex_we_q;

        if (bus.flush || stall_c || !bus.id_valid) begin
            ex_valid_d = 1'b0;
            ex_rd_d    = '0;
            ex_we_d    = 1'b0;
            ex_ld_d    = 1'b0;
            sel_a_d    = SEL_RF;
            sel_b_d    = SEL_RF;
        end else begin
            ex_valid_d = 1'b1;
            ex_rd_d    = bus.id_rd;
            ex_we_d    = bus.id_we;
            ex_ld_d    = bus.id_ld;
            sel_a_d    = pick_sel(bus.id_rs, ex_wr, ex_rd_q, mem_wr, mem_rd_q);
            sel_b_d    = pick_sel(bus.id_rt, ex_wr, ex_rd_q, mem_wr, mem_rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign bus.stall    = stall_c;
    assign bus.ex_sel_a = sel_a_q;
    assign bus.ex_sel_b = sel_b_q;
    assign bus.ex_valid = ex_valid_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed hazard scenarios plus randomized instruction streams,
// checked against a list-of-older-instructions reference model.
module tb_fwd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_ctrl_if #(.AW(3)) bus ();

    fwd_ctrl #(.AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       we;
        logic       ld;
    } rec_t;

    // older[0] is the instruction in EX, older[1] the one in MEM
    rec_t       older [2];
    logic [1:0] m_sel_a, m_sel_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [2:0] s);
        if (s == 3'd0) return 2'd0;
        for (int i = 0; i < 2; i++)
            if (older[i].v && older[i].we && older[i].rd == s)
                return 2'(i + 1);
        return 2'd0;
    endfunction

    // Drive one ID slot, check the current-cycle outputs at negedge, then advance the model.
    task automatic cycle(input logic r, input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic we, input logic ld, input logic fl,
                         output logic st);
        logic       exp_st;
        logic [1:0] na, nb;
        rst = r;
        bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_we = we; bus.id_ld = ld; bus.flush = fl;
        @(negedge clk);
        exp_st = v && !fl && older[0].v && older[0].ld && older[0].we && older[0].rd != 3'd0 &&
                 (older[0].rd == rs || older[0].rd == rt);
        chk("stall", int'(bus.stall), int'(exp_st));
        chk("ex_valid", int'(bus.ex_valid), int'(older[0].v));
        chk("sel_a", int'(bus.ex_sel_a), int'(m_sel_a));
        chk("sel_b", int'(bus.ex_sel_b), int'(m_sel_b));
        st = bus.stall;
        na = ref_sel(rs);
        nb = ref_sel(rt);
        if (r) begin
            older[0] = '0; older[1] = '0; m_sel_a = 2'd0; m_sel_b = 2'd0;
        end else begin
            older[1] = older[0];
            older[1].ld = 1'b0;
            if (fl || exp_st || !v) begin
                older[0] = '0; m_sel_a = 2'd0; m_sel_b = 2'd0;
            end else begin
                older[0] = '{v: 1'b1, rd: rd, we: we, ld: ld};
                m_sel_a = na; m_sel_b = nb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic       st;
    logic [2:0] rs, rt, rd;
    logic       v, we, ld, fl, r;

    initial begin
        older[0] = '0; older[1] = '0; m_sel_a = 2'd0; m_sel_b = 2'd0;
        rst = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs = 3'd1; bus.id_rt = 3'd2; bus.id_rd = 3'd3;
        bus.id_we = 1'b1; bus.id_ld = 1'b1; bus.flush = 1'b0;
        @(posedge clk);
        #1;

        // reset held with id_valid=1
        cycle(1, 1, 3'd1, 3'd2, 3'd3, 1, 1, 0, st);
        cycle(1, 1, 3'd1, 3'd2, 3'd3, 1, 1, 0, st);
        chk("rst_exv", int'(bus.ex_valid), 0);
        chk("rst_sela", int'(bus.ex_sel_a), 0);
        chk("rst_selb", int'(bus.ex_sel_b), 0);
        chk("rst_stall", int'(bus.stall), 0);

        // EX forward
        cycle(0, 1, 3'd0, 3'd0, 3'd3, 1, 0, 0, st);
        cycle(0, 1, 3'd3, 3'd5, 3'd1, 1, 0, 0, st);
        chk("exfwd_stall", int'(st), 0);
        chk("exfwd_a", int'(bus.ex_sel_a), 1);
        chk("exfwd_b", int'(bus.ex_sel_b), 0);

        // MEM forward through a nop
        cycle(0, 1, 3'd0, 3'd0, 3'd4, 1, 0, 0, st);
        cycle(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, st);
        cycle(0, 1, 3'd4, 3'd0, 3'd1, 1, 0, 0, st);
        chk("memfwd_a", int'(bus.ex_sel_a), 2);

        // back-to-back writers: EX wins, both sources identical
        cycle(0, 1, 3'd0, 3'd0, 3'd4, 1, 0, 0, st);
        cycle(0, 1, 3'd0, 3'd0, 3'd4, 1, 0, 0, st);
        cycle(0, 1, 3'd4, 3'd4, 3'd1, 1, 0, 0, st);
        chk("prio_a", int'(bus.ex_sel_a), 1);
        chk("prio_b", int'(bus.ex_sel_b), 1);

        // load-use: one stall, bubble, then MEM forward
        cycle(0, 1, 3'd0, 3'd0, 3'd2, 1, 1, 0, st);
        cycle(0, 1, 3'd1, 3'd2, 3'd5, 1, 0, 0, st);
        chk("lu_stall", int'(st), 1);
        chk("lu_bubble", int'(bus.ex_valid), 0);
        cycle(0, 1, 3'd1, 3'd2, 3'd5, 1, 0, 0, st);
        chk("lu_stall2", int'(st), 0);
        chk("lu_exv", int'(bus.ex_valid), 1);
        chk("lu_a", int'(bus.ex_sel_a), 0);
        chk("lu_b", int'(bus.ex_sel_b), 2);

        // load followed by consumer two slots later
        cycle(0, 1, 3'd0, 3'd0, 3'd6, 1, 1, 0, st);
        cycle(0, 1, 3'd1, 3'd2, 3'd0, 0, 0, 0, st);
        chk("lu_unrel", int'(st), 0);
        cycle(0, 1, 3'd6, 3'd0, 3'd1, 1, 0, 0, st);
        chk("lu_far_st", int'(st), 0);
        chk("lu_far_a", int'(bus.ex_sel_a), 2);

        // register 0 and non-writers
        cycle(0, 1, 3'd0, 3'd0, 3'd0, 1, 0, 0, st);
        cycle(0, 1, 3'd0, 3'd0, 3'd1, 1, 0, 0, st);
        chk("r0_a", int'(bus.ex_sel_a), 0);
        cycle(0, 1, 3'd0, 3'd0, 3'd6, 0, 0, 0, st);
        cycle(0, 1, 3'd6, 3'd0, 3'd1, 0, 0, 0, st);
        chk("store_a", int'(bus.ex_sel_a), 0);
        cycle(0, 1, 3'd0, 3'd0, 3'd0, 1, 1, 0, st);
        cycle(0, 1, 3'd0, 3'd0, 3'd1, 1, 0, 0, st);
        chk("ld_r0_st", int'(st), 0);

        // flush beats stall
        cycle(0, 1, 3'd0, 3'd0, 3'd2, 1, 1, 0, st);
        cycle(0, 1, 3'd2, 3'd0, 3'd1, 1, 0, 1, st);
        chk("fl_stall", int'(st), 0);
        chk("fl_exv", int'(bus.ex_valid), 0);

        // reset in the stall cycle
        cycle(0, 1, 3'd0, 3'd0, 3'd2, 1, 1, 0, st);
        cycle(1, 1, 3'd2, 3'd0, 3'd1, 1, 0, 0, st);
        chk("rstst_was", int'(st), 1);
        chk("rstst_exv", int'(bus.ex_valid), 0);
        chk("rstst_a", int'(bus.ex_sel_a), 0);
        chk("rstst_b", int'(bus.ex_sel_b), 0);
        chk("rstst_stall", int'(bus.stall), 0);

        // randomized stream; ID held while stalled
        st = 1'b0;
        rs = 3'd0; rt = 3'd0; rd = 3'd0; we = 1'b0; ld = 1'b0; v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 7) == 0);
            if (!st || r) begin
                v  = ($urandom_range(0, 7) != 0);
                rs = 3'($urandom_range(0, 3));
                rt = 3'($urandom_range(0, 3));
                rd = 3'($urandom_range(0, 3));
                we = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 2) == 0);
            end
            cycle(r, v, rs, rt, rd, we, ld, fl, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 16-bit pipeline. It tracks the destination register of the instructions in EX and MEM, and compares them against the source registers of the instruction in ID. It produces registered select codes for the two EX-stage 3:1 operand muxes: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result. It also raises a stall when an instruction in ID needs a load result that is still in EX.

## Interface
Parameters:
- AW, 3, register address width (register 0 is hardwired zero).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  AW  ID source register A.
- id_rt  in  AW  ID source register B.
- id_rd  in  AW  ID destination register.
- id_we  in  1  ID instruction writes id_rd.
- id_ld  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction this cycle (branch taken).
- stall  out  1  combinational; hold PC and IF/ID, inject a bubble into EX.
- ex_sel_a  out  2  registered select for EX operand A mux.
- ex_sel_b  out  2  registered select for EX operand B mux.
- ex_valid  out  1  registered; EX holds a real instruction.

## Operation
- Internal stage records EX = {valid, rd, we, ld} and MEM = {valid, rd, we}.
- "Writer" for a stage: valid && we && rd != 0.
- Hit definitions:
  - EX hit on source s: EX is a writer and EX.rd == s.
  - MEM hit on source s: MEM is a writer and MEM.rd == s.
- Next select per source, s = id_rs for A and id_rt for B:
  - EX hit → 1.
  - else MEM hit → 2.
  - else → 0.
  - EX hit has priority when both stages hit (youngest value wins).
  - Source 0 always gives 0. Code 3 is never produced.
- No WB-stage comparison is made: the register file writes before it reads in the same cycle.
- Load-use: stall = id_valid && !flush && EX.valid && EX.ld && EX.we && EX.rd != 0 && (EX.rd == id_rs || EX.rd == id_rt).
- Every edge, MEM ← EX unconditionally. This block never stalls EX or MEM.
- Every edge, EX load depends on the priority below:
  - rst: EX and MEM valid ← 0; ex_sel_a/b ← 0.
  - flush, or stall, or !id_valid: EX ← bubble (valid 0, we 0, ld 0); ex_sel_a/b ← 0.
  - otherwise: EX ← {1, id_rd, id_we, id_ld}; ex_sel_a/b ← next select.
- Priority order: rst > flush > stall > normal.
- Only EX.valid, EX.we and MEM.valid must reset. rd and ld may reset to 0.

## Timing
- Reset values:
  - stall = 0, ex_sel_a = 0, ex_sel_b = 0, ex_valid = 0.
  - All stage valids = 0.
- Select latency: compare in ID cycle n; the result appears on ex_sel_* in cycle n+1, aligned with the instruction in EX.
- stall is combinational from the ID inputs and EX state, in the same cycle.
- During stall, the ID inputs are held by the upstream stage.
- In the cycle after a stall:
  - The load is in MEM, so the re-evaluated compare yields sel 2 for that register.
  - stall deasserts, because EX now holds the bubble.
- A load followed by an unrelated instruction causes no stall.
- A load followed by a consumer two slots later yields sel 2 with no stall.
- Back-to-back writers to the same rd, then a consumer: sel 1 (EX wins).
- flush and stall in the same cycle: flush wins, bubble inserted, stall output 0.
- rst asserted mid-stall: on the next edge all state clears, and stall is 0 in the following cycle.
- Same register on both sources (rs == rt == hit): both selects take the identical code.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 → ex_valid=0, ex_sel_a=ex_sel_b=0, stall=0.
- EX forward: issue add r3 (we=1), then an instruction with rs=3, rt=5 → next cycle ex_sel_a=1, ex_sel_b=0, stall never asserted.
- MEM forward and priority:
  - issue r4 writer, nop, then rs=4 → ex_sel_a=2.
  - issue r4, r4, then rs=4 → ex_sel_a=1.
- Load-use: issue load r2, then rs=1, rt=2 → stall=1 for exactly 1 cycle. ex_valid=0 in the bubble cycle. Then ex_valid=1 with ex_sel_b=2, ex_sel_a=0.
- Register 0 and non-writers:
  - writer with rd=0, then rs=0 → sel 0.
  - store (we=0) with rd=6, then rs=6 → sel 0.
  - load r0 followed by rs=0 → no stall.
- Flush/reset collisions:
  - load r2, then rs=2 with flush=1 → stall=0, next ex_valid=0.
  - load r2, then rs=2, with rst pulsed in the stall cycle → all outputs 0 next cycle.
